dm_store_mem: RTL
=================

// Module: dm_store_mem
// PURPOSE
//  Data memory for the MEM stage of the P6 pipeline. Performs word, halfword and byte stores
//  through a byte-merge path. Returns the raw aligned 32-bit word at the access address to
//  the downstream load-extension stage, which picks and extends byte/half lanes using addr[1:0].
//  After reset, a sweep FSM clears every word; stores are accepted only once the clear is done.
//  A registered store-log port lets the bench compare writes against the reference model.
// PARAMETERS
//  DEPTH_LOG2  12  log2 of the word count (default 4096 words = 16 KiB), word-addressed
// PORTS
//  clk        in   1   single clock; all state updates on the rising edge
//  reset      in   1   synchronous, active-low reset
//  pc         in   32  PC of the instruction in MEM; used only for the log
//  mem_addr   in   32  byte address from the ALU result
//  wdata      in   32  store data (rt value after forwarding)
//  store_op   in   2   00 none, 01 sw, 10 sh, 11 sb
//  rd         out  32  raw word at mem_addr[DEPTH_LOG2+1:2]; goes to the load extender
//  ready      out  1   1 = clear sweep finished, so stores are accepted
//  misalign   out  1   combinational flag: sw with addr[1:0]!=0, or sh with addr[0]!=0
//  log_valid  out  1   pulses for one cycle, one cycle after an accepted store
//  log_pc     out  32  PC of the logged store
//  log_addr   out  32  {mem_addr[31:2],2'b00} of the logged store
//  log_data   out  32  full merged word written
// BEHAVIOUR
//  - Word index idx = mem_addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so
//    addresses wrap modulo the memory size.
//  - Reset (reset==0 at an edge): FSM -> CLEAR, sweep counter -> 0, ready=0,
//    log_valid=0, log_pc/log_addr/log_data=0. Reset wins over a store in the same cycle.
//  - FSM CLEAR: each cycle writes 0 to mem[cnt], then cnt+=1. Moves to RUN on the edge
//    that clears word DEPTH-1, so ready goes high exactly DEPTH cycles after reset is released.
//    Reset during the sweep restarts it at cnt=0. While in CLEAR, rd=0 and every
//    store_op is ignored (no write, no log).
//  - FSM RUN: stays in RUN until the next reset. A store is accepted when store_op!=0,
//    misalign==0 and ready==1.
//  - Merge (old word W = mem[idx]):
//      sw: new = wdata
//      sh: addr[1]=0 -> {W[31:16],wdata[15:0]}; addr[1]=1 -> {wdata[15:0],W[15:0]}
//      sb: wdata[7:0] goes to lane addr[1:0] (lane 0 = bits 7:0); other lanes keep W
//  - An accepted store writes the merged word at the rising edge. On that same edge the log
//    registers capture pc, the word address and the merged word, and log_valid=1 for that cycle.
//  - A misaligned store makes no write and produces no log; misalign is still driven
//    for the trap/bench. store_op==00 drives misalign=0.
//  - rd is an asynchronous read of mem[idx]. A store and a read of the same word in one
//    cycle: rd shows the old word until the edge and the new word afterwards. No internal bypass.
//  - Back-to-back stores to the same word merge correctly: each merge uses the current mem
//    contents, so sb to lanes 0 then 1 on consecutive cycles keeps both bytes.
//  - This block never stalls; ready is informational for the top level and holds the
//    pipeline in reset-sweep.
// STRUCTURE
//  - Shared package p6_mem_pkg holds the STORE_NONE/SW/SH/SB encodings, the FSM state
//    enum {CLEAR,RUN} and the load-op encodings used by the downstream extender.
//  - One sub-module: store_merge. It is purely combinational: (W, wdata, addr[1:0], store_op)
//    -> merged word and misalign.
//  - Top level holds the memory array, the sweep FSM/counter and the log registers.
// TESTING (use DEPTH_LOG2=4 for speed)
//  1 Release reset: ready=0 for 16 cycles and rd=0 throughout; ready=1 on cycle 16; all
//    words read 0.
//  2 sw 0x12345678 @0x8, then sb 0xAB @0xA -> rd@0x8=0x12AB5678; log_data of the second
//    store = 0x12AB5678 with log_valid for 1 cycle.
//  3 sh 0xBEEF @0x6 over 0x11223344 -> 0xBEEF3344; sh @0x4 -> 0x1122BEEF.
//  4 sw @0x5 and sh @0x3 -> misalign=1, no memory change, log_valid stays 0.
//  5 sw 0xCAFEF00D @0x40 (wraps to idx 0) -> rd@0x0=0xCAFEF00D.
//  6 Assert reset mid-sweep at cnt=7, and again with a sw active in RUN -> sweep restarts
//    (16 more cycles), no write/log from that sw, memory all zero afterwards.

Source files
------------

// File: rtl/p6_mem_pkg.sv
// rtl/p6_mem_pkg.sv - shared store/load encodings and sweep state type for the P6 MEM stage
// Purpose: encodings shared by the data memory, its store-merge path and the
//          downstream load extender.
// Ports:   none (package)
package p6_mem_pkg;

  localparam logic [1:0] STORE_NONE = 2'b00;
  localparam logic [1:0] STORE_SW   = 2'b01;
  localparam logic [1:0] STORE_SH   = 2'b10;
  localparam logic [1:0] STORE_SB   = 2'b11;

  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LBU  = 3'd2;
  localparam logic [2:0] LOAD_LH   = 3'd3;
  localparam logic [2:0] LOAD_LHU  = 3'd4;
  localparam logic [2:0] LOAD_LW   = 3'd5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } mem_state_t;

endpackage

// File: rtl/store_merge.sv
// rtl/store_merge.sv - combinational byte-merge of store data into the old memory word
// Purpose: builds the word to write for sw/sh/sb and flags misaligned accesses.
// Ports:   i_old_word  current word at the target index
//          i_wdata     store data
//          i_addr_lo   mem_addr[1:0]
//          i_store_op  store encoding (none/sw/sh/sb)
//          o_merged    word to be written
//          o_misalign  sw with addr[1:0]!=0 or sh with addr[0]!=0
module store_merge
  import p6_mem_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_store_op,
  output logic [31:0] o_merged,
  output logic        o_misalign
);

  always_comb begin
    o_merged   = i_old_word;
    o_misalign = 1'b0;
    case (i_store_op)
      STORE_SW: begin
        o_misalign = (i_addr_lo != 2'b00);
        o_merged   = i_wdata;
      end
      STORE_SH: begin
        o_misalign = i_addr_lo[0];
        if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
        else              o_merged[15:0]  = i_wdata[15:0];
      end
      STORE_SB: begin
        // lane 0 is bits 7:0; lane select is addr[1:0] * 8
        o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      end
      default: begin
        o_merged   = i_old_word;
        o_misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dm_store_mem.sv
// rtl/dm_store_mem.sv - P6 MEM-stage data memory with store merge, clear sweep and store log
// Purpose: word-addressed data memory. After reset a sweep clears every word; only
//          then are stores accepted. rd is the raw aligned word for the load extender.
// Ports:   clk, reset (sync, active-low)
//          pc, mem_addr, wdata, store_op       instruction in MEM
//          rd, ready, misalign                 read word, sweep done, alignment flag
//          log_valid, log_pc, log_addr, log_data  registered record of each accepted store
module dm_store_mem
  import p6_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] mem_addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  store_op,
  output logic [31:0] rd,
  output logic        ready,
  output logic        misalign,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] CNT_ONE = 1;

  logic [31:0]           r_mem [DEPTH];
  mem_state_t            r_state;
  mem_state_t            w_state_next;
  logic [DEPTH_LOG2-1:0] r_cnt;
  logic                  w_ready;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_old;
  logic [31:0]           w_merged;
  logic                  w_misalign;
  logic                  w_accept;

  logic                  r_log_valid;
  logic [31:0]           r_log_pc;
  logic [31:0]           r_log_addr;
  logic [31:0]           r_log_data;

  // upper address bits are dropped: accesses wrap modulo the memory size
  assign w_idx = mem_addr[DEPTH_LOG2+1:2];
  assign w_old = r_mem[w_idx];

  store_merge u_store_merge (
    .i_old_word (w_old),
    .i_wdata    (wdata),
    .i_addr_lo  (mem_addr[1:0]),
    .i_store_op (store_op),
    .o_merged   (w_merged),
    .o_misalign (w_misalign)
  );

  assign w_accept = (store_op != STORE_NONE) && !w_misalign && w_ready;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_CLEAR;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        // leave on the edge that clears the last word
        if (&r_cnt) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_ready = 1'b1;
      end
      default: w_state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)                  r_cnt <= '0;
    else if (r_state == ST_CLEAR) r_cnt <= r_cnt + CNT_ONE;
  end

  // no reset on the array itself; the sweep does the clearing, and a
  // reset edge blocks both the sweep write and any store
  always_ff @(posedge clk) begin
    if (reset) begin
      if (r_state == ST_CLEAR) r_mem[r_cnt] <= '0;
      else if (w_accept)       r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_log_valid <= 1'b0;
      r_log_pc    <= '0;
      r_log_addr  <= '0;
      r_log_data  <= '0;
    end else begin
      r_log_valid <= w_accept;
      if (w_accept) begin
        r_log_pc   <= pc;
        r_log_addr <= {mem_addr[31:2], 2'b00};
        r_log_data <= w_merged;
      end
    end
  end

  assign rd        = w_ready ? w_old : '0;
  assign ready     = w_ready;
  assign misalign  = w_misalign;
  assign log_valid = r_log_valid;
  assign log_pc    = r_log_pc;
  assign log_addr  = r_log_addr;
  assign log_data  = r_log_data;

endmodule
